display_scanner: RTL

Parametrised multiplexed seven-segment display driver: time-multiplexes `DIGITS` hex digits onto one shared segment bus with per-digit active-low enables. It supersedes the fixed 4-digit scan logic in the board top level. It adds:
- a configurable refresh prescaler;
- a tear-free per-frame data snapshot;
- a per-digit blank mask;
- PWM brightness control;
- optional leading-zero suppression.

It sits between the data source (for example, the CDC handler output) and the board display pins.

---
 rtl/display_scanner_if.sv | 23 ++
 rtl/display_scanner.sv | 130 +++++++++++++
 2 files changed

// File: rtl/display_scanner_if.sv
// Bus between a hex data source and the multiplexed seven-segment scanner.
// The master drives digit data, blank mask and brightness; the slave drives the display pins.
interface display_scanner_if #(
    parameter int DIGITS      = 4,
    parameter int BRIGHT_BITS = 3
);
    logic [4*DIGITS-1:0]  DATA;
    logic [DIGITS-1:0]    BLANK;
    logic [BRIGHT_BITS:0] BRIGHTNESS;
    logic [DIGITS-1:0]    DS_EN;
    logic [6:0]           DS_SEG;
    logic                 FRAME_START;

    modport master (
        output DATA, BLANK, BRIGHTNESS,
        input  DS_EN, DS_SEG, FRAME_START
    );

    modport slave (
        input  DATA, BLANK, BRIGHTNESS,
        output DS_EN, DS_SEG, FRAME_START
    );
endinterface

// File: rtl/display_scanner.sv
// Multiplexed seven-segment scanner with per-frame snapshot, blank mask and PWM brightness.
// Define DISPLAY_SCANNER_LZS_EN to build leading-zero suppression.
module display_scanner #(
    parameter int DIGITS      = 4,
    parameter int DIV_BITS    = 13,
    parameter int BRIGHT_BITS = 3
) (
    input  logic              CLK,
    input  logic              RST,
    display_scanner_if.slave  bus
);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [BRIGHT_BITS:0] BRIGHT_FULL = {1'b1, {BRIGHT_BITS{1'b0}}};

    logic [DIV_BITS-1:0]    pre;
    logic [IDX_W-1:0]       idx;
    logic [4*DIGITS-1:0]    snap;
    logic [DIGITS-1:0]      blank_s;
    logic [BRIGHT_BITS:0]   bright_s;

    logic [IDX_W-1:0]       idx_s1;
    logic [6:0]             seg_s1;
    logic                   show_s1;
    logic                   fs_s1;
    logic [DIGITS-1:0]      en_q;
    logic [6:0]             seg_q;

    logic                   frame_start;
    logic [4*DIGITS-1:0]    cur_snap;
    logic [DIGITS-1:0]      cur_blank;
    logic [BRIGHT_BITS:0]   cur_bright;
    logic [BRIGHT_BITS-1:0] lvl;
    logic [3:0]             nib;
    logic                   suppressed;
    logic                   show;
    logic [IDX_W-1:0]       idx_next;
    logic [DIGITS-1:0]      en_next;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1111110;
            4'h1: hex7 = 7'b0110000;
            4'h2: hex7 = 7'b1101101;
            4'h3: hex7 = 7'b1111001;
            4'h4: hex7 = 7'b0110011;
            4'h5: hex7 = 7'b1011011;
            4'h6: hex7 = 7'b1011111;
            4'h7: hex7 = 7'b1110000;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1111011;
            4'hA: hex7 = 7'b1110111;
            4'hB: hex7 = 7'b0011111;
            4'hC: hex7 = 7'b1001110;
            4'hD: hex7 = 7'b0111101;
            4'hE: hex7 = 7'b1001111;
            default: hex7 = 7'b1000111;
        endcase
    endfunction

    // The first slot of a frame must already see the values captured this cycle.
    assign frame_start = (pre == '0) && (idx == '0) && !RST;
    assign cur_snap    = frame_start ? bus.DATA       : snap;
    assign cur_blank   = frame_start ? bus.BLANK      : blank_s;
    assign cur_bright  = frame_start ? bus.BRIGHTNESS : bright_s;

    assign lvl      = pre[DIV_BITS-1 -: BRIGHT_BITS];
    assign nib      = cur_snap[4*int'(idx) +: 4];
    assign idx_next = (idx == IDX_W'(DIGITS-1)) ? '0 : idx + 1'b1;

`ifdef DISPLAY_SCANNER_LZS_EN
    logic [DIGITS-1:0] supp;
    logic              zero_above;

    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
        supp       = '0;
        zero_above = 1'b1;
        for (int k = DIGITS-1; k >= 1; k--) begin
            zero_above = zero_above && (cur_snap[4*k +: 4] == 4'h0);
            supp[k]    = zero_above;
        end
    end

    assign suppressed = supp[idx];
`else
    assign suppressed = 1'b0;
`endif

    assign show = ({1'b0, lvl} < cur_bright) && !cur_blank[idx] && !suppressed;

    always_comb begin
        en_next = '1;
        if (show_s1) en_next[idx_s1] = 1'b0;
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pre      <= '0;
            idx      <= '0;
            snap     <= '0;
            blank_s  <= '0;
            bright_s <= BRIGHT_FULL;
            idx_s1   <= '0;
            seg_s1   <= '0;
            show_s1  <= 1'b0;
            fs_s1    <= 1'b0;
            en_q     <= '1;
            seg_q    <= '0;
        end else begin
            pre <= pre + 1'b1;
            if (&pre) idx <= idx_next;
            if (frame_start) begin
                snap     <= bus.DATA;
                blank_s  <= bus.BLANK;
                bright_s <= bus.BRIGHTNESS;
            end
            idx_s1  <= idx;
            seg_s1  <= hex7(nib);
            show_s1 <= show;
            fs_s1   <= frame_start;
            en_q    <= en_next;
            seg_q   <= show_s1 ? seg_s1 : 7'b0;
        end
    end

    assign bus.DS_EN       = en_q;
    assign bus.DS_SEG      = seg_q;
    assign bus.FRAME_START = fs_s1;
endmodule
